val2_shift_seq: RTL and testbench

VAL2_SHIFT_SEQ -- requirements
Module: val2_shift_seq

---
 rtl/val2_shift_seq.sv | 137 +++++++++++++
 tb/tb_val2_shift_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_seq.sv
// ==========================================================================
// val2_shift_seq : sequential ARM val2 shifter, one 1-bit step per cycle
// Rev 1.0
// ==========================================================================
`default_nettype none

module val2_shift_seq #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [11:0]     shift_op,
  input  logic [WORD-1:0] val_Rm,
  input  logic            imm,
  input  logic            is_mem_cmd,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'd0;
  localparam logic [1:0] M_LSR = 2'd1;
  localparam logic [1:0] M_ASR = 2'd2;
  localparam logic [1:0] M_ROR = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [WORD-1:0] work;
  logic [WORD-1:0] dec_work;
  logic [WORD-1:0] step_work;
  logic [4:0]      count;
  logic [4:0]      dec_count;
  logic [1:0]      mode;
  logic [1:0]      dec_mode;
  logic            accept;

  assign accept = start && !flush;

  // Operand decode, priority mem > imm > immediate-shift > register-shift.
  always_comb begin
    dec_work  = val_Rm;
    dec_count = 5'd0;
    dec_mode  = M_LSL;
    if (is_mem_cmd) begin
      dec_work = {{(WORD-12){1'b0}}, shift_op};
    end else if (imm) begin
      dec_work  = {{(WORD-8){1'b0}}, shift_op[7:0]};
      dec_mode  = M_ROR;
      dec_count = {shift_op[11:8], 1'b0};
    end else if (!shift_op[4]) begin
      dec_mode  = shift_op[6:5];
      dec_count = shift_op[11:7];
    end
  end

  always_comb begin
    step_work = work;
    case (mode)
      M_LSL:   step_work = {work[WORD-2:0], 1'b0};
      M_LSR:   step_work = {1'b0, work[WORD-1:1]};
      M_ASR:   step_work = {work[WORD-1], work[WORD-1:1]};
      M_ROR:   step_work = {work[0], work[WORD-1:1]};
      default: step_work = work;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (dec_count == 5'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (flush)                state_nxt = IDLE;
        else if (count <= 5'd1)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Result is published on the edge that leaves DONE, so done and out rise together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work  <= '0;
      count <= '0;
      mode  <= M_LSL;
      done  <= 1'b0;
      out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= dec_work;
            count <= dec_count;
            mode  <= dec_mode;
          end
        end
        SHIFT: begin
          if (flush) begin
            work  <= '0;
            count <= '0;
          end else begin
            work  <= step_work;
            count <= count - 5'd1;
          end
        end
        DONE: begin
          if (!flush) begin
            out  <= work;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_val2_shift_seq.sv
// Bench for val2_shift_seq: latency/result model plus directed literal cases.
`default_nettype none

module tb_val2_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [11:0] shift_op;
  logic [31:0] val_Rm;
  logic        imm;
  logic        is_mem_cmd;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  // Model: pending op, cycles left before the done edge, result, published out.
  logic        m_pending;
  int          m_left;
  logic [31:0] m_res;
  logic        m_done;
  logic [31:0] m_out;

  val2_shift_seq #(.WORD(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .shift_op(shift_op),
    .val_Rm(val_Rm), .imm(imm), .is_mem_cmd(is_mem_cmd),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_val2(input logic mem, input logic im,
                                         input logic [11:0] sop, input logic [31:0] v,
                                         output int cnt);
    logic signed [31:0] sv;
    int n;
    cnt = 0;
    if (mem) return {20'b0, sop};
    if (im) begin
      n = 2 * int'(sop[11:8]);
      cnt = n;
      return ror32({24'b0, sop[7:0]}, n);
    end
    if (sop[4]) return v;
    n = int'(sop[11:7]);
    cnt = n;
    sv = v;
    case (sop[6:5])
      2'b00:   return v << n;
      2'b01:   return v >> n;
      2'b10:   return sv >>> n;
      default: return ror32(v, n);
    endcase
  endfunction

  task automatic model_reset();
    m_pending = 1'b0;
    m_left    = 0;
    m_res     = '0;
    m_done    = 1'b0;
    m_out     = '0;
  endtask

  task automatic model_update();
    int c;
    if (!rst) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (m_pending) begin
      if (flush) m_pending = 1'b0;
      else if (m_left == 0) begin
        m_out     = m_res;
        m_done    = 1'b1;
        m_pending = 1'b0;
      end else m_left--;
    end else if (start && !flush) begin
      m_res     = m_val2(is_mem_cmd, imm, shift_op, val_Rm, c);
      m_left    = c;
      m_pending = 1'b1;
    end
  endtask

  // Inputs change only at negedge, so the model sees exactly what the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("busy", {31'b0, busy}, {31'b0, m_pending});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("out", out, m_out);
    end
  end

  task automatic run_dir(input string name, input logic mem, input logic im,
                         input logic [11:0] sop, input logic [31:0] v,
                         input logic [31:0] exp_out, input int exp_lat);
    int lat;
    logic got;
    is_mem_cmd = mem; imm = im; shift_op = sop; val_Rm = v; start = 1'b1;
    cycle();
    start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      cycle();
      lat++;
      if (done) got = 1'b1;
    end
    chk({name, "_seen"}, {31'b0, got}, 32'd1);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_out"}, out, exp_out);
  endtask

  initial begin
    int c;
    logic [31:0] prev;
    rst = 1'b0; start = 1'b0; flush = 1'b0; shift_op = '0; val_Rm = '0;
    imm = 1'b0; is_mem_cmd = 1'b0;
    model_reset();

    chk("model_imm", m_val2(1'b0, 1'b1, 12'h2FF, 32'h0, c), 32'hF000000F);
    chk("model_imm_cnt", c, 4);
    chk("model_asr", m_val2(1'b0, 1'b0, 12'h240, 32'h80000000, c), 32'hF8000000);

    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_out", out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    run_dir("imm_2ff", 1'b0, 1'b1, 12'h2FF, 32'h0, 32'hF000000F, 5);
    run_dir("asr4", 1'b0, 1'b0, 12'h240, 32'h80000000, 32'hF8000000, 5);
    run_dir("mem_abc", 1'b1, 1'b0, 12'hABC, 32'hFFFFFFFF, 32'h00000ABC, 1);

    // Flush sampled on the third edge after the start edge.
    prev = out;
    is_mem_cmd = 1'b0; imm = 1'b0; shift_op = 12'hFE0; val_Rm = 32'h12345678; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_out", out, prev);
    repeat (35) cycle();
    chk("flush_out_hold", out, prev);
    run_dir("ror31", 1'b0, 1'b0, 12'hFE0, 32'h12345678, 32'h2468ACF0, 32);

    run_dir("lsl0", 1'b0, 1'b0, 12'h000, 32'h12345678, 32'h12345678, 1);
    run_dir("lsr1_b2b", 1'b0, 1'b0, 12'h0A0, 32'h12345678, 32'h091A2B3C, 2);

    // Asynchronous reset between edges during SHIFT.
    is_mem_cmd = 1'b0; imm = 1'b0; shift_op = 12'hFE0; val_Rm = 32'hDEADBEEF; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_done", {31'b0, done}, 32'd0);
    chk("async_out", out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_dir("post_rst_imm", 1'b0, 1'b1, 12'h0AB, 32'h0, 32'h000000AB, 1);

    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom % 3) != 0;
      flush      = ($urandom % 20) == 0;
      is_mem_cmd = ($urandom % 4) == 0;
      imm        = ($urandom % 3) == 0;
      shift_op   = 12'($urandom);
      shift_op[4] = ($urandom % 8) == 0;
      val_Rm     = $urandom;
      cycle();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
